// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths and fetch FSM state encoding.
package instruction_fetch_unit_pkg;
  localparam int DEFAULT_ROM_ADDRESS_WIDTH = 16;
  localparam int DEFAULT_INSTRUCTION_WIDTH = 64;
  typedef enum logic {FETCH_IDLE = 1'b0, FETCH_RUN = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: registered output stage plus one-entry skid carrying {pc, instruction}.
module fetch_skid_buffer #(
  parameter int W = 80
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         skid_valid_o
);
  logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, load;
  logic [W-1:0] out_q, out_d, skid_q, skid_d;
  always_comb begin
    load         = !out_valid_q || out_ready_i;
    out_valid_d  = !flush_i && (load ? (skid_valid_q || in_valid_i) : 1'b1);
    out_d        = (load && skid_valid_q) ? skid_q : (load && in_valid_i) ? in_data_i : out_q;
    skid_valid_d = !flush_i && (load ? (skid_valid_q && in_valid_i) : (skid_valid_q || in_valid_i));
    skid_d       = (in_valid_i && (skid_valid_q || !load)) ? in_data_i : skid_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_q;
  assign skid_valid_o = skid_valid_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC/FSM owner streaming ROM words to the decoder through a skid buffer.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ROM_ADDRESS_WIDTH = DEFAULT_ROM_ADDRESS_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         iTrigger,
  input  logic [ROM_ADDRESS_WIDTH-1:0] iEntryPoint,
  output logic [ROM_ADDRESS_WIDTH-1:0] oIMemAddr,
  output logic                         oIMemRead,
  input  logic [INSTRUCTION_WIDTH-1:0] iIMemInput,
  output logic [INSTRUCTION_WIDTH-1:0] oInstruction,
  output logic                         oInstructionValid,
  output logic [ROM_ADDRESS_WIDTH-1:0] oInstructionPC,
  input  logic                         iDecodeReady,
  input  logic                         iBranchTaken,
  input  logic [ROM_ADDRESS_WIDTH-1:0] iBranchTarget,
  input  logic                         iStop,
  output logic                         oBusy
);
  localparam int W = ROM_ADDRESS_WIDTH + INSTRUCTION_WIDTH;
  fetch_state_e                 state_q, state_d;
  logic [ROM_ADDRESS_WIDTH-1:0] pc_q, pc_d, in_flight_pc_q, in_flight_pc_d;
  logic                         in_flight_q, in_flight_d, run, flush, pop, out_valid, skid_valid;
  logic [1:0]                   occupancy;
  logic [W-1:0]                 out_data;
  always_comb begin
    run            = state_q == FETCH_RUN;
    flush          = run && (iBranchTaken || iStop);
    pop            = out_valid && iDecodeReady;
    occupancy      = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, in_flight_q};
    // An issue now lands next cycle, so leave room for it after this cycle's pop.
    oIMemRead      = run && !flush && (occupancy - {1'b0, pop}) < 2'd2;
    state_d        = !run ? (iTrigger ? FETCH_RUN : FETCH_IDLE) : (!iBranchTaken && iStop) ? FETCH_IDLE : FETCH_RUN;
    pc_d           = !run ? (iTrigger ? iEntryPoint : pc_q) : iBranchTaken ? iBranchTarget :
                     oIMemRead ? pc_q + ROM_ADDRESS_WIDTH'(1) : pc_q;
    in_flight_d    = oIMemRead;
    in_flight_pc_d = oIMemRead ? pc_q : in_flight_pc_q;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= FETCH_IDLE;
      pc_q           <= '0;
      in_flight_q    <= 1'b0;
      in_flight_pc_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      in_flight_q    <= in_flight_d;
      in_flight_pc_q <= in_flight_pc_d;
    end
  end
  fetch_skid_buffer #(.W(W)) u_skid (
    .clk_i       (Clock),
    .rst_ni      (Reset),
    .flush_i     (flush),
    .in_valid_i  (in_flight_q),
    .in_data_i   ({in_flight_pc_q, iIMemInput}),
    .out_ready_i (iDecodeReady),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .skid_valid_o(skid_valid)
  );
  assign oInstructionValid              = out_valid;
  assign {oInstructionPC, oInstruction} = out_data;
  assign oIMemAddr                      = pc_q;
  assign oBusy                          = run;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table, corner sequences and a randomized stream-model check.
module tb_instruction_fetch_unit;
  localparam int AW = 16;
  localparam int IW = 64;
  logic          Clock = 1'b0, Reset = 1'b0, iTrigger = 1'b0, iDecodeReady = 1'b0, iBranchTaken = 1'b0, iStop = 1'b0;
  logic [AW-1:0] iEntryPoint = '0, iBranchTarget = '0;
  logic [IW-1:0] iIMemInput;
  logic [AW-1:0] oIMemAddr, oInstructionPC;
  logic          oIMemRead, oInstructionValid, oBusy;
  logic [IW-1:0] oInstruction;
  int vectors = 0, miscompares = 0;

  always #5 Clock = ~Clock;

  instruction_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .iTrigger(iTrigger), .iEntryPoint(iEntryPoint),
    .oIMemAddr(oIMemAddr), .oIMemRead(oIMemRead), .iIMemInput(iIMemInput),
    .oInstruction(oInstruction), .oInstructionValid(oInstructionValid), .oInstructionPC(oInstructionPC),
    .iDecodeReady(iDecodeReady), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .iStop(iStop), .oBusy(oBusy)
  );

  function automatic logic [IW-1:0] rom_word(logic [AW-1:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
  endfunction

  // Synchronous ROM: word for the issued address appears one cycle later; junk otherwise.
  always @(posedge Clock) iIMemInput <= oIMemRead ? rom_word(oIMemAddr) : {$urandom, $urandom};

  task automatic chk(string name, logic [IW-1:0] got, logic [IW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(logic rdy, logic trig, logic [AW-1:0] entry, logic br, logic [AW-1:0] tgt, logic stp);
    iDecodeReady = rdy; iTrigger = trig; iEntryPoint = entry;
    iBranchTaken = br; iBranchTarget = tgt; iStop = stp;
  endtask

  task automatic chk_out(string name, logic [AW-1:0] pc);
    chk({name, "_valid"}, 64'(oInstructionValid), 64'(1));
    chk({name, "_pc"}, 64'(oInstructionPC), 64'(pc));
    chk({name, "_data"}, oInstruction, rom_word(pc));
  endtask

  typedef struct {
    logic rdy, trig; logic [AW-1:0] entry; logic br; logic [AW-1:0] tgt; logic stp;
    logic ev; logic [AW-1:0] epc; logic er, eb;
  } vec_t;
  vec_t tbl[24];

  function automatic vec_t mk(logic rdy, logic trig, logic [AW-1:0] entry, logic br, logic [AW-1:0] tgt,
                              logic stp, logic ev, logic [AW-1:0] epc, logic er, logic eb);
    vec_t v;
    v.rdy = rdy; v.trig = trig; v.entry = entry; v.br = br; v.tgt = tgt; v.stp = stp;
    v.ev = ev; v.epc = epc; v.er = er; v.eb = eb;
    return v;
  endfunction

  initial begin
    logic          busy_m, obs_valid;
    logic [AW-1:0] exp_pc;
    int            since;
    // Each row: inputs held for one cycle, outputs expected during that cycle.
    tbl[0]  = mk(1, 1, 16'h0010, 0, 0, 0,       0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0,              0, 0, 1, 1);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0,              0, 0, 1, 1);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0,              1, 16'h0010, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,              1, 16'h0011, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,              1, 16'h0011, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,              1, 16'h0011, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0,              1, 16'h0011, 1, 1);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0,              1, 16'h0012, 1, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0,              1, 16'h0013, 1, 1);
    tbl[10] = mk(1, 0, 0, 1, 16'h0100, 0,       1, 16'h0014, 0, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 0,              0, 0, 1, 1);
    tbl[12] = mk(1, 0, 0, 0, 0, 0,              0, 0, 1, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 0,              1, 16'h0100, 1, 1);
    tbl[14] = mk(1, 0, 0, 0, 0, 1,              1, 16'h0101, 0, 1);
    tbl[15] = mk(1, 1, 16'hFFFE, 1, 16'h0777, 1, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 16'h0200, 0, 0, 0,       0, 0, 1, 1);
    tbl[17] = mk(1, 0, 0, 0, 0, 0,              0, 0, 1, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 0,              1, 16'hFFFE, 1, 1);
    tbl[19] = mk(1, 0, 0, 0, 0, 0,              1, 16'hFFFF, 1, 1);
    tbl[20] = mk(1, 0, 0, 1, 16'h0300, 1,       1, 16'h0000, 0, 1);
    tbl[21] = mk(1, 0, 0, 0, 0, 0,              0, 0, 1, 1);
    tbl[22] = mk(1, 0, 0, 0, 0, 0,              0, 0, 1, 1);
    tbl[23] = mk(1, 0, 0, 0, 0, 0,              1, 16'h0300, 1, 1);

    #2;
    chk("rst_valid", 64'(oInstructionValid), 64'(0));
    chk("rst_busy", 64'(oBusy), 64'(0));
    chk("rst_read", 64'(oIMemRead), 64'(0));
    chk("rst_addr", 64'(oIMemAddr), 64'(0));
    chk("rst_pc", 64'(oInstructionPC), 64'(0));
    chk("rst_instr", oInstruction, 64'(0));
    @(negedge Clock); Reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge Clock);
      drive(tbl[i].rdy, tbl[i].trig, tbl[i].entry, tbl[i].br, tbl[i].tgt, tbl[i].stp);
      #1;
      chk($sformatf("row%0d_valid", i), 64'(oInstructionValid), 64'(tbl[i].ev));
      chk($sformatf("row%0d_busy", i), 64'(oBusy), 64'(tbl[i].eb));
      chk($sformatf("row%0d_read", i), 64'(oIMemRead), 64'(tbl[i].er));
      if (tbl[i].ev) chk_out($sformatf("row%0d", i), tbl[i].epc);
    end

    // Branch while stalled with the skid full: both buffered words must vanish.
    @(negedge Clock); drive(0, 0, 0, 0, 0, 0);
    @(negedge Clock); drive(0, 0, 0, 1, 16'h0040, 0); #1;
    chk_out("skidfull_hold", 16'h0301);
    chk("skidfull_read", 64'(oIMemRead), 64'(0));
    @(negedge Clock); drive(1, 0, 0, 0, 0, 0); #1;
    chk("brflush_v0", 64'(oInstructionValid), 64'(0));
    @(negedge Clock); #1;
    chk("brflush_v1", 64'(oInstructionValid), 64'(0));
    @(negedge Clock); #1; chk_out("brtgt0", 16'h0040);
    @(negedge Clock); #1; chk_out("brtgt1", 16'h0041);

    // Async reset between edges with the skid full.
    @(negedge Clock); drive(0, 0, 0, 0, 0, 0);
    @(negedge Clock); #1;
    chk("prerst_read", 64'(oIMemRead), 64'(0));
    #2 Reset = 1'b0; #1;
    chk("arst_valid", 64'(oInstructionValid), 64'(0));
    chk("arst_busy", 64'(oBusy), 64'(0));
    chk("arst_read", 64'(oIMemRead), 64'(0));
    chk("arst_addr", 64'(oIMemAddr), 64'(0));
    chk("arst_pc", 64'(oInstructionPC), 64'(0));
    chk("arst_instr", oInstruction, 64'(0));
    @(negedge Clock); Reset = 1'b1; drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock); #1;
      chk("idle_busy", 64'(oBusy), 64'(0));
      chk("idle_valid", 64'(oInstructionValid), 64'(0));
      chk("idle_read", 64'(oIMemRead), 64'(0));
    end
    @(negedge Clock); drive(1, 1, 16'h0200, 0, 0, 0);
    @(negedge Clock); drive(1, 0, 0, 0, 0, 0); #1;
    chk("retrig_busy", 64'(oBusy), 64'(1));
    chk("retrig_v0", 64'(oInstructionValid), 64'(0));
    @(negedge Clock); #1; chk("retrig_v1", 64'(oInstructionValid), 64'(0));
    @(negedge Clock); #1; chk_out("retrig0", 16'h0200);
    @(negedge Clock); #1; chk_out("retrig1", 16'h0201);
    @(negedge Clock); drive(1, 0, 0, 0, 0, 1);
    @(negedge Clock); drive(1, 0, 0, 0, 0, 0); #1;
    chk("stop_busy", 64'(oBusy), 64'(0));
    chk("stop_valid", 64'(oInstructionValid), 64'(0));

    // Random phase: model is the expected instruction stream plus start-up latency.
    busy_m = 1'b0; exp_pc = '0; since = 3;
    repeat (3000) begin
      @(negedge Clock);
      chk("rnd_busy", 64'(oBusy), 64'(busy_m));
      chk("rnd_valid", 64'(oInstructionValid), 64'(busy_m && since >= 2));
      if (oInstructionValid) chk_out("rnd", exp_pc);
      obs_valid = oInstructionValid;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 3) == 0) ? 16'hFFFC + AW'($urandom_range(0, 3)) : AW'($urandom),
            $urandom_range(0, 24) == 0,
            ($urandom_range(0, 3) == 0) ? 16'hFFFD + AW'($urandom_range(0, 2)) : AW'($urandom),
            $urandom_range(0, 39) == 0);
      #1;
      if (!busy_m || iBranchTaken || iStop) chk("rnd_noread", 64'(oIMemRead), 64'(0));
      @(posedge Clock);
      if (busy_m) begin
        if (iBranchTaken) begin exp_pc = iBranchTarget; since = 0; end
        else if (iStop) busy_m = 1'b0;
        else begin
          if (obs_valid && iDecodeReady) exp_pc = exp_pc + 16'd1;
          if (since < 3) since++;
        end
      end else if (iTrigger) begin
        busy_m = 1'b1; exp_pc = iEntryPoint; since = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Downstream neighbour of the entry-point stage: consumes its one-cycle trigger pulse and entry address, then streams instructions from the synchronous instruction ROM to the decoder.
- Owns the program counter, issues ROM reads and absorbs the ROM's one-cycle read latency with a one-entry skid buffer.
- Supports decoder backpressure, taken branches (flush plus redirect) and program stop (flush plus return to idle).

Parameters:
- ROM_ADDRESS_WIDTH, 16, instruction ROM address width; the PC wraps modulo 2^ROM_ADDRESS_WIDTH.
- INSTRUCTION_WIDTH, 64, width of one instruction word.

Ports:
- Clock  in  1  sole clock, posedge.
- Reset  in  1  asynchronous, active-low reset.
- iTrigger  in  1  start pulse from the entry-point stage.
- iEntryPoint  in  ROM_ADDRESS_WIDTH  first PC, sampled when iTrigger=1.
- oIMemAddr  out  ROM_ADDRESS_WIDTH  ROM read address; equals rPC.
- oIMemRead  out  1  ROM read issue strobe.
- iIMemInput  in  INSTRUCTION_WIDTH  ROM data, valid one cycle after issue.
- oInstruction  out  INSTRUCTION_WIDTH  instruction presented to the decoder.
- oInstructionValid  out  1  oInstruction is valid.
- oInstructionPC  out  ROM_ADDRESS_WIDTH  address of oInstruction.
- iDecodeReady  in  1  decoder accepts oInstruction this cycle.
- iBranchTaken  in  1  redirect request.
- iBranchTarget  in  ROM_ADDRESS_WIDTH  redirect address.
- iStop  in  1  end of program; return to idle.
- oBusy  out  1  high while state is RUN.

Behaviour:
- Reset (asynchronous, Reset=0): state IDLE; rPC, rInFlight, rOutValid, rSkidValid and all data/PC registers = 0. Outputs: oIMemRead=0, oInstructionValid=0, oBusy=0, oInstruction=0, oInstructionPC=0, oIMemAddr=0. Reset may assert mid-fetch and mid-stall; there is no residual state.
- States: IDLE, RUN.
- IDLE:
  - iTrigger=1 → rPC<=iEntryPoint, state RUN.
  - Otherwise hold.
  - iBranchTaken and iStop are ignored in IDLE.
- RUN:
  - iTrigger is ignored.
  - Event priority: iBranchTaken > iStop > normal.
- Accounting terms:
  - occupancy = rOutValid + rSkidValid + rInFlight.
  - pop = rOutValid & iDecodeReady.
  - Issue is allowed iff (occupancy - pop) < 2.
- Normal issue: oIMemRead=1 → rPC<=rPC+1 (wraps from all-ones to 0), rInFlight<=1, rInFlightPC<=rPC. If no issue, rInFlight<=0.
- Data arrival (rInFlight=1), the cycle after issue:
  - If the skid is empty and (rOutValid=0 or pop): iIMemInput goes to the output register.
  - Otherwise it goes to the skid register.
  - The skid drains to the output when (rOutValid=0 or pop). Skid order always precedes new data.
- Output register rules:
  - oInstruction, oInstructionValid and oInstructionPC are registered.
  - They hold stable while oInstructionValid=1 and iDecodeReady=0.
- Latency:
  - iTrigger sampled at edge k → address=entry issued during cycle k+1 → oInstructionValid=1 after edge k+2.
  - Throughput is 1 instruction/cycle while iDecodeReady=1.
- Branch (RUN, iBranchTaken=1 at edge):
  - rPC<=iBranchTarget.
  - rOutValid, rSkidValid, rInFlight <= 0, so data returning next cycle is discarded.
  - oIMemRead=0 in the branch cycle.
  - First target instruction is valid 2 edges later.
- Stop (RUN, iStop=1 at edge): same flush as a branch, then state IDLE.
- Simultaneous iBranchTaken and iStop: branch wins, state stays RUN.
- Invariants: never more than 2 instructions buffered or in flight; no instruction dropped or duplicated except by flush.

Decomposition:
- Shared definitions package: ROM_ADDRESS_WIDTH and INSTRUCTION_WIDTH defaults, and state encodings FETCH_IDLE=1'b0, FETCH_RUN=1'b1.
- One natural sub-module, fetch_skid_buffer: output register plus one-entry skid with valid/ready, carrying {PC, instruction}. The top level keeps the FSM, the PC and issue accounting.

Test Plan:
- Basic stream: iEntryPoint=0x0010, iTrigger pulse, iDecodeReady=1, ROM word=address → oInstructionValid 2 edges after trigger; PCs 0x10,0x11,0x12… one per cycle, data matches.
- Backpressure: drop iDecodeReady for 3 cycles mid-stream → output held stable, oIMemRead=0 once occupancy reaches 2; on release, PCs continue with no gap, loss or duplicate.
- Branch: at PC 0x14 valid, iBranchTaken=1 with target 0x0100 → 0x15 and any in-flight word never appear; next valid PC=0x0100 two edges later. Also branch while stalled with skid full: both entries flushed.
- Stop and retrigger: iStop mid-stream → oBusy=0 and oInstructionValid=0 next cycle. Retrigger with entry 0x0200 → stream restarts at 0x0200. iTrigger during RUN has no effect. iBranchTaken+iStop together → branch taken, oBusy stays 1.
- Wrap: entry 0xFFFE → PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Async reset: assert Reset=0 between edges while the skid is full → all outputs 0 immediately, without a clock edge; after release the block is idle until iTrigger.
